// File: rtl/modexp_sequencer.sv
// modexp_sequencer: square-and-multiply controller scanning the exponent MSB first and driving mul/mod go/done handshakes.
// Optional macro LEADING_ZERO_SKIP_EN skips leading zero exponent bits (not constant-time).
module modexp_sequencer #(
   parameter int EXP_WIDTH = 32,
   parameter int IDX_W     = $clog2(EXP_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [2:0]           cmd,
   input  logic [EXP_WIDTH-1:0] e_in,
   input  logic                 init_done,
   input  logic                 mul_done,
   input  logic                 mod_done,
   output logic                 update_n,
   output logic                 initialize,
   output logic                 mul_go,
   output logic                 mul_sel,
   output logic                 mod_go,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   localparam logic [2:0] CMD_START  = 3'd1;
   localparam logic [2:0] CMD_LOAD_N = 3'd2;
   localparam logic [2:0] CMD_LOAD_E = 3'd3;
   localparam logic [2:0] CMD_ABORT  = 3'd4;

   typedef enum logic [3:0] {
      IDLE, INIT, SCAN, SQ_MUL_GO, SQ_MUL_WAIT, SQ_MOD_GO, SQ_MOD_WAIT,
      BM_MUL_GO, BM_MUL_WAIT, BM_MOD_GO, BM_MOD_WAIT, NEXT, FIN
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [EXP_WIDTH-1:0] e_reg_q, e_reg_d;
   logic                 n_valid_q, n_valid_d, e_valid_q, e_valid_d;
   logic                 update_n_q, update_n_d, initialize_q, initialize_d;
   logic                 mul_go_q, mul_go_d, mul_sel_q, mul_sel_d, mod_go_q, mod_go_d;
   logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      e_reg_d    = e_reg_q;
      n_valid_d  = n_valid_q;
      e_valid_d  = e_valid_q;
      update_n_d = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            update_n_d = cmd == CMD_LOAD_N;
            n_valid_d  = n_valid_q | (cmd == CMD_LOAD_N);
            if (cmd == CMD_LOAD_E) begin
               e_reg_d   = e_in;
               e_valid_d = 1'b1;
            end
            if (cmd == CMD_START) begin
               if (n_valid_q && e_valid_q) state_d = INIT;
               else err_d = 1'b1;
            end
         end
         INIT: if (init_done) begin
            idx_d   = IDX_W'(EXP_WIDTH - 1);
            state_d = SCAN;
         end
         SCAN: begin
`ifdef LEADING_ZERO_SKIP_EN
            // result is still 1 here, so the first set bit needs no square
            if (e_reg_q[idx_q]) state_d = BM_MUL_GO;
            else if (idx_q == '0) state_d = FIN;
            else idx_d = idx_q - IDX_W'(1);
`else
            state_d = SQ_MUL_GO;
`endif
         end
         SQ_MUL_GO:   state_d = SQ_MUL_WAIT;
         SQ_MUL_WAIT: if (mul_done) state_d = SQ_MOD_GO;
         SQ_MOD_GO:   state_d = SQ_MOD_WAIT;
         SQ_MOD_WAIT: if (mod_done) state_d = e_reg_q[idx_q] ? BM_MUL_GO : NEXT;
         BM_MUL_GO:   state_d = BM_MUL_WAIT;
         BM_MUL_WAIT: if (mul_done) state_d = BM_MOD_GO;
         BM_MOD_GO:   state_d = BM_MOD_WAIT;
         BM_MOD_WAIT: if (mod_done) state_d = NEXT;
         NEXT: begin
            if (idx_q == '0) state_d = FIN;
            else begin
               idx_d   = idx_q - IDX_W'(1);
               state_d = SQ_MUL_GO;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && cmd == CMD_ABORT) state_d = IDLE;
      // Moore outputs are registered copies of the next-state decode
      initialize_d = state_d == INIT;
      mul_go_d     = state_d == SQ_MUL_GO || state_d == BM_MUL_GO;
      mod_go_d     = state_d == SQ_MOD_GO || state_d == BM_MOD_GO;
      mul_sel_d    = state_d inside {BM_MUL_GO, BM_MUL_WAIT, BM_MOD_GO, BM_MOD_WAIT};
      busy_d       = state_d != IDLE && state_d != FIN;
      done_d       = state_d == FIN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         e_reg_q      <= '0;
         n_valid_q    <= 1'b0;
         e_valid_q    <= 1'b0;
         update_n_q   <= 1'b0;
         initialize_q <= 1'b0;
         mul_go_q     <= 1'b0;
         mul_sel_q    <= 1'b0;
         mod_go_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         e_reg_q      <= e_reg_d;
         n_valid_q    <= n_valid_d;
         e_valid_q    <= e_valid_d;
         update_n_q   <= update_n_d;
         initialize_q <= initialize_d;
         mul_go_q     <= mul_go_d;
         mul_sel_q    <= mul_sel_d;
         mod_go_q     <= mod_go_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign update_n   = update_n_q;
   assign initialize = initialize_q;
   assign mul_go     = mul_go_q;
   assign mul_sel    = mul_sel_q;
   assign mod_go     = mod_go_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
endmodule

// File: tb/tb_modexp_sequencer.sv
// tb_modexp_sequencer: table-driven and randomized checks of modexp_sequencer (EXP_WIDTH=4) against
// a square-and-multiply operation model, with a latency-programmable datapath responder.
module tb_modexp_sequencer;
   localparam int W = 4;
`ifdef LEADING_ZERO_SKIP_EN
   localparam bit LZS = 1'b1;
`else
   localparam bit LZS = 1'b0;
`endif
   localparam logic [2:0] C_NONE = 3'd0, C_START = 3'd1, C_LOAD_N = 3'd2, C_LOAD_E = 3'd3, C_ABORT = 3'd4;

   typedef struct {
      logic [W-1:0] e;
      int           lat;
      int           ops_plain;
      int           ops_lzs;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [2:0]   cmd = C_NONE;
   logic [W-1:0] e_in = '0;
   logic         init_done = 1'b0, mul_done = 1'b0, mod_done = 1'b0;
   logic         update_n, initialize, mul_go, mul_sel, mod_go, busy, done, err;

   int checks = 0, errors = 0;
   int lat_r = 3;
   bit stray_go = 1'b0, stray_wait = 1'b0;
   int init_cnt = 0, mul_cnt = 0, mod_cnt = 0;

   modexp_sequencer #(.EXP_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .e_in(e_in),
      .init_done(init_done), .mul_done(mul_done), .mod_done(mod_done),
      .update_n(update_n), .initialize(initialize), .mul_go(mul_go), .mul_sel(mul_sel),
      .mod_go(mod_go), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // datapath: init_done on the 2nd initialize cycle, done pulses lat_r cycles after each go
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            init_cnt = 0;
            mul_cnt  = 0;
            mod_cnt  = 0;
         end
         init_cnt  = initialize ? init_cnt + 1 : 0;
         init_done = init_cnt == 2;
         mul_done  = 1'b0;
         mod_done  = 1'b0;
         if (mul_cnt > 0) begin mul_cnt--; mul_done = mul_cnt == 0; end
         if (mod_cnt > 0) begin mod_cnt--; mod_done = mod_cnt == 0; end
         if (mul_go) mul_cnt = lat_r;
         if (mod_go) mod_cnt = lat_r;
         if (stray_go && mul_go) mul_done = 1'b1;
         if (stray_wait && (mod_cnt == 1 || mod_cnt == 2)) mul_done = 1'b1;
      end
   end

   function automatic logic [7:0] outs();
      return {update_n, initialize, mul_go, mul_sel, mod_go, busy, done, err};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic issue(input logic [2:0] c);
      cmd = c;
      step();
      cmd = C_NONE;
   endtask

   // Expected mul_sel sequence (sentinel-led bit string), op count and busy length
   task automatic model(input logic [W-1:0] e, input int lat, output longint code, output int ops, output int bcyc);
      bit started = 1'b0;
      int nexts = 0, scan;
      code = 1;
      ops  = 0;
      for (int i = W - 1; i >= 0; i--) begin
         if (!LZS || started) begin code = code * 2; ops++; end
         if (e[i]) begin code = code * 2 + 1; ops++; started = 1'b1; end
         if (!LZS || started) nexts++;
      end
      scan = !LZS ? 1 : (nexts == 0 ? W : W - nexts + 1);
      bcyc = 2 + scan + ops * 2 * (lat + 1) + nexts;
   endtask

   task automatic run_exp(input logic [W-1:0] e, input int lat, input int exp_ops, input string nm);
      longint code, got = 1;
      int ops, bexp, bcyc = 0, gos = 0, mods = 0, dones = 0, gaps = 0, errs = 0, sel_bad = 0;
      logic last_sel = 1'b0, busy_at_done = 1'b1;
      model(e, lat, code, ops, bexp);
      lat_r = lat;
      e_in  = e;
      issue(C_LOAD_E);
      cmd = C_START;
      step();
      cmd = C_NONE;
      for (int c = 0; c < 2000 && dones == 0; c++) begin
         if (done) begin
            dones++;
            busy_at_done = busy;
         end else begin
            if (busy) bcyc++; else gaps++;
            if (mul_go) begin got = got * 2 + longint'(mul_sel); last_sel = mul_sel; gos++; end
            if (mod_go) begin mods++; if (mul_sel !== last_sel) sel_bad++; end
            if (err) errs++;
            step();
         end
      end
      chk({nm, "_done_seen"}, dones, 1);
      chk({nm, "_sel_seq"}, got, code);
      chk({nm, "_mod_per_mul"}, mods, gos);
      chk({nm, "_busy_cycles"}, bcyc, bexp);
      chk({nm, "_busy_gap"}, gaps, 0);
      chk({nm, "_busy_at_done"}, busy_at_done, 0);
      chk({nm, "_sel_stable"}, sel_bad, 0);
      chk({nm, "_no_err"}, errs, 0);
      if (exp_ops >= 0) chk({nm, "_ops"}, gos, exp_ops);
      step();
      chk({nm, "_done_pulse"}, done, 0);
   endtask

   initial begin
      vec_t vt [7];
      int   n0, dn;
      bit   found;
      vt[0] = '{4'b1011, 3, 7, 6};
      vt[1] = '{4'b0010, 3, 5, 2};
      vt[2] = '{4'b0000, 2, 4, 0};
      vt[3] = '{4'b1111, 1, 8, 7};
      vt[4] = '{4'b0001, 4, 5, 1};
      vt[5] = '{4'b1000, 2, 5, 4};
      vt[6] = '{4'b0101, 3, 6, 4};

      repeat (3) step();
      chk("reset_outs", outs(), 0);
      rst_n = 1'b1;
      step();
      chk("after_reset_outs", outs(), 0);

      issue(C_START);
      chk("start_no_n_err", err, 1);
      chk("start_no_n_busy", busy, 0);
      chk("start_no_n_init", initialize, 0);
      step();
      chk("err_pulse_len", err, 0);

      issue(C_LOAD_N);
      chk("update_n_pulse", update_n, 1);
      step();
      chk("update_n_len", update_n, 0);
      issue(C_START);
      chk("start_no_e_err", err, 1);
      step();

      for (int i = 0; i < 7; i++)
         run_exp(vt[i].e, vt[i].lat, LZS ? vt[i].ops_lzs : vt[i].ops_plain, $sformatf("vec%0d", i));

      for (int i = 0; i < 20; i++)
         run_exp(W'($urandom_range(0, 15)), int'($urandom_range(1, 4)), -1, $sformatf("rand%0d", i));

      stray_go   = 1'b1;
      stray_wait = 1'b1;
      run_exp(4'b1011, 3, LZS ? 6 : 7, "stray");
      stray_go   = 1'b0;
      stray_wait = 1'b0;
      repeat (4) step();

      // abort in the square-reduction wait of the second scanned bit
      lat_r = 3;
      e_in  = 4'b1011;
      issue(C_LOAD_E);
      cmd = C_START;
      step();
      cmd   = C_NONE;
      n0    = 0;
      found = 1'b0;
      for (int c = 0; c < 500 && !found; c++) begin
         if (mod_go && !mul_sel) begin n0++; found = n0 == 2; end
         if (!found) step();
      end
      chk("abort_reached", found, 1);
      step();
      cmd = C_ABORT;
      chk("abort_busy_before", busy, 1);
      step();
      cmd = C_NONE;
      chk("abort_busy_drop", busy, 0);
      dn = 0;
      for (int c = 0; c < 8; c++) begin
         dn += int'(done) + int'(err) + int'(busy);
         step();
      end
      chk("abort_quiet", dn, 0);
      run_exp(4'b1011, 3, LZS ? 6 : 7, "after_abort");

      // asynchronous reset during a base-multiply wait
      e_in = 4'b1011;
      issue(C_LOAD_E);
      cmd = C_START;
      step();
      cmd   = C_NONE;
      found = 1'b0;
      for (int c = 0; c < 500 && !found; c++) begin
         if (mul_go && mul_sel) found = 1'b1;
         else step();
      end
      chk("bm_reached", found, 1);
      step();
      chk("bm_wait_sel", mul_sel, 1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outs", outs(), 0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      chk("post_reset_quiet", outs(), 0);
      issue(C_START);
      chk("post_reset_err", err, 1);
      chk("post_reset_busy", busy, 0);
      chk("post_reset_init", initialize, 0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/modexp_sequencer.md
Name: modexp_sequencer

Overview:
- Parametrised controller for square-and-multiply modular exponentiation.
- Accepts load/start/abort commands and holds the exponent internally.
- Scans exponent bits MSB to LSB and drives the multiplier and reducer datapath through explicit go/done handshakes.
- Sits between the host command interface and the multiply/modulo datapath; reports busy, done and error.

Parameters:
- EXP_WIDTH, 32, exponent width in bits; legal range 2..4096.
- IDX_W, $clog2(EXP_WIDTH), width of the bit index counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd  input  3  0 NONE, 1 START, 2 LOAD_N, 3 LOAD_E, 4 ABORT; 5-7 treated as NONE.
- e_in  input  EXP_WIDTH  exponent, captured on LOAD_E.
- init_done  input  1  datapath result register preset to 1 and base latched.
- mul_done  input  1  one-cycle pulse: product ready.
- mod_done  input  1  one-cycle pulse: reduction ready.
- update_n  output  1  one-cycle pulse: datapath latches modulus.
- initialize  output  1  level: datapath presets result=1 and latches base.
- mul_go  output  1  one-cycle pulse: start multiply.
- mul_sel  output  1  0 = result*result, 1 = result*base; stable from mul_go until mod_done.
- mod_go  output  1  one-cycle pulse: start reduction.
- busy  output  1  high while an exponentiation is in progress.
- done  output  1  one-cycle pulse on completion.
- err  output  1  one-cycle pulse when START is rejected.

Behaviour:
- All outputs are registered (Moore) and reset to 0. State resets to IDLE; n_valid, e_valid and e_reg reset to 0.
- The reset is asynchronous and active-low; the clock is clk. Reset mid-operation returns to IDLE immediately, with no done and no err.
- States: IDLE, INIT, SCAN, SQ_MUL_GO, SQ_MUL_WAIT, SQ_MOD_GO, SQ_MOD_WAIT, BM_MUL_GO, BM_MUL_WAIT, BM_MOD_GO, BM_MOD_WAIT, NEXT, FIN.
- IDLE, LOAD_N: pulse update_n next cycle; set n_valid.
- IDLE, LOAD_E: e_reg<=e_in; set e_valid. No update_e output.
- IDLE, START:
  - If n_valid and e_valid: go to INIT and set busy.
  - Otherwise: pulse err next cycle and stay in IDLE.
- INIT: initialize held high until init_done is sampled. Then set idx=EXP_WIDTH-1 and go to SCAN.
- SCAN (no macro): pass straight to SQ_MUL_GO, 1 cycle.
- SQ_MUL_GO: mul_go=1, mul_sel=0, 1 cycle; then SQ_MUL_WAIT.
- SQ_MUL_WAIT: on mul_done go to SQ_MOD_GO.
- SQ_MOD_GO: mod_go=1, 1 cycle.
- SQ_MOD_WAIT: on mod_done, go to BM_MUL_GO if e_reg[idx]=1, else NEXT.
- BM_* states: mirror the SQ_* states with mul_sel=1.
- NEXT:
  - idx==0: go to FIN.
  - Otherwise: idx<=idx-1 and go to SQ_MUL_GO.
- FIN: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- Handshake rules:
  - done inputs are sampled only in the matching WAIT state.
  - A done arriving during a GO cycle or in any other state is ignored.
  - The datapath must not assert done in the same cycle as the go pulse.
- ABORT in any state other than IDLE: return to IDLE next cycle; busy drops; no done, no err. n_valid and e_valid are kept.
- While busy, LOAD_N, LOAD_E and START are ignored; e_reg cannot change mid-run.
- Operation count: EXP_WIDTH squarings plus popcount(e_reg) base multiplies.
- e_reg=0: result stays 1. Squarings still occur without the macro.

Optional Feature:
- Macro: LEADING_ZERO_SKIP_EN.
- Defined:
  - SCAN tests e_reg[idx]. While it is 0 and idx>0, decrement idx one per cycle with no datapath activity.
  - At the first set bit, skip the square (result is 1) and go directly to BM_MUL_GO.
  - If e_reg=0, SCAN reaches idx=0 with the bit clear and goes to FIN; no mul_go or mod_go is issued.
  - Timing then depends on the exponent (not constant-time).
- Undefined: uniform, constant operation count as specified above.

Test Plan:
- EXP_WIDTH=4, LOAD_N, LOAD_E e=4'b1011, START, with the datapath answering done 3 cycles after each go:
  - 7 mul_go pulses with mul_sel sequence 0,1,0,0,1,0,1.
  - 7 mod_go pulses.
  - One done; busy high from the cycle after START until the done cycle.
- START after reset with no LOAD_N: err pulse 1 cycle later; busy stays 0; no initialize.
- e=4'b0010:
  - Without macro: mul_sel sequence 0,0,0,1,0.
  - With LEADING_ZERO_SKIP_EN: 2 SCAN skip cycles, then sequence 1,0.
  - e=0 with macro: done with zero mul_go.
- ABORT during SQ_MOD_WAIT of the second bit: busy=0 next cycle; no done. A following START runs to completion normally.
- mul_done asserted during the SQ_MUL_GO cycle, or twice during SQ_MOD_WAIT: stray pulses are ignored and exactly one mod_go per mul_go is issued.
- rst_n low during BM_MUL_WAIT: all outputs 0 asynchronously; after release, START gives err (n_valid cleared).
